// File: rtl/pipe_mw_pkg.sv
// pipe_mw_pkg: shared widths, payload struct and state encoding for the elastic MEM->WB stage
package pipe_mw_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int RN_W_DEF = 5;
  localparam int CNT_W_DEF = 16;
  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic [DATA_W_DEF-1:0] mo;
    logic [DATA_W_DEF-1:0] alu;
    logic [RN_W_DEF-1:0] rn;
  } mw_payload_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} mw_state_t;
endpackage

// File: rtl/pipe_mw_slot.sv
// pipe_mw_slot: load-enabled payload register, cleared by asynchronous reset
// ports: clock, reset (async, active-high), ld (load enable), d (next payload), q (held payload)
module pipe_mw_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= '0;
    else if (ld) q <= d;
endmodule

// File: rtl/pipe_mw_elastic.sv
// pipe_mw_elastic: elastic MEM->WB stage with 2-entry skid buffer, valid/ready on both sides and flush
// ports: clock, reset (async, active-high), flush (sync);
//   MEM side: m_valid, m_ready, mwreg, mm2reg, mmo, malu, mrn;
//   WB side: w_valid, w_ready, wwreg, wm2reg (both gated by w_valid), wmo, walu, wrn;
//   stall_cnt only when PIPE_MW_STALL_CNT_EN is defined (saturating count of stalled valid cycles)
module pipe_mw_elastic
  import pipe_mw_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RN_W = RN_W_DEF
`ifdef PIPE_MW_STALL_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [DATA_W-1:0] mmo,
  input  logic [DATA_W-1:0] malu,
  input  logic [RN_W-1:0]   mrn,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [DATA_W-1:0] wmo,
  output logic [DATA_W-1:0] walu,
  output logic [RN_W-1:0]   wrn
`ifdef PIPE_MW_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);
  localparam int PW = 2 * DATA_W + RN_W + 2;
  mw_state_t state, state_nxt;
  logic in_fire, out_fire, main_ld, skid_ld, main_wreg, main_m2reg;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  assign in_fire = m_valid & m_ready;
  assign out_fire = w_valid & w_ready;
  assign in_pl = {mwreg, mm2reg, mmo, malu, mrn};
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = flush ? EMPTY :
                state == EMPTY ? (in_fire ? ONE : EMPTY) :
                state == ONE ? (in_fire & ~out_fire ? FULL : ~in_fire & out_fire ? EMPTY : ONE) :
                (out_fire ? ONE : FULL);
  end
  // m_ready decodes only the state register, so w_ready never reaches it combinationally
  always_comb begin
    m_ready = state != FULL;
    w_valid = state != EMPTY;
  end
  // flush suppresses every load: the offered payload is dropped and slots keep their contents
  assign main_ld = ~flush & (state == FULL ? out_fire : in_fire & (state == EMPTY | out_fire));
  assign skid_ld = ~flush & (state == ONE) & in_fire & ~out_fire;
  assign main_d = state == FULL ? skid_q : in_pl;
  pipe_mw_slot #(.W(PW)) u_main (
    .clock(clock), .reset(reset), .ld(main_ld), .d(main_d), .q(main_q)
  );
  pipe_mw_slot #(.W(PW)) u_skid (
    .clock(clock), .reset(reset), .ld(skid_ld), .d(in_pl), .q(skid_q)
  );
  assign {main_wreg, main_m2reg, wmo, walu, wrn} = main_q;
  assign wwreg = main_wreg & w_valid;
  assign wm2reg = main_m2reg & w_valid;
`ifdef PIPE_MW_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) stall_cnt <= '0;
    else if (w_valid & ~w_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_pipe_mw_elastic.sv
// tb_pipe_mw_elastic: directed and randomized checks of pipe_mw_elastic against a queue model
module tb_pipe_mw_elastic;
  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0] rn;
  } pl_t;
`ifdef PIPE_MW_STALL_CNT_EN
  localparam int CMAX = 15;
`endif
  logic clock = 0, reset = 1, flush = 0, m_valid = 0, w_ready = 1, mwreg = 0, mm2reg = 0;
  logic [31:0] mmo = 0, malu = 0;
  logic [4:0] mrn = 0;
  logic m_ready, w_valid, wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0] wrn;
`ifdef PIPE_MW_STALL_CNT_EN
  logic [3:0] stall_cnt;
`endif
  int checks = 0, errors = 0;
  pl_t q[$];
  pl_t last = '0;
  int cnt = 0;
  logic inf, outf;

  pipe_mw_elastic #(
    .DATA_W(32), .RN_W(5)
`ifdef PIPE_MW_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .mwreg(mwreg), .mm2reg(mm2reg), .mmo(mmo), .malu(malu), .mrn(mrn),
    .w_valid(w_valid), .w_ready(w_ready), .wwreg(wwreg), .wm2reg(wm2reg),
    .wmo(wmo), .walu(walu), .wrn(wrn)
`ifdef PIPE_MW_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // reference: a FIFO of at most two payloads; the W side shows the oldest one,
  // and the last payload shown stays visible on the data outputs once the FIFO empties
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      last = '0;
      cnt = 0;
    end else begin
      inf = m_valid && q.size() < 2;
      outf = q.size() > 0 && w_ready;
`ifdef PIPE_MW_STALL_CNT_EN
      if (q.size() > 0 && !w_ready && cnt < CMAX) cnt++;
`endif
      if (flush) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back({mwreg, mm2reg, mmo, malu, mrn});
      end
      if (q.size() > 0) last = q[0];
    end
  end

  always @(negedge clock) begin
    check("w_valid", w_valid, q.size() > 0);
    check("m_ready", m_ready, q.size() < 2);
    check("wwreg", wwreg, q.size() > 0 && last.wreg);
    check("wm2reg", wm2reg, q.size() > 0 && last.m2reg);
    check("wmo", wmo, last.mo);
    check("walu", walu, last.alu);
    check("wrn", wrn, last.rn);
`ifdef PIPE_MW_STALL_CNT_EN
    check("stall_cnt", stall_cnt, cnt);
`endif
  end

  task automatic offer(input logic v, input logic [4:0] rn, input logic [31:0] alu);
    m_valid = v;
    mrn = rn;
    malu = alu;
    mmo = {alu[15:0], alu[15:0]};
    mwreg = 1;
    mm2reg = rn[0];
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset w_valid", w_valid, 0);
    check("reset m_ready", m_ready, 1);
    check("reset wrn", wrn, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      offer(1, 5'(i + 1), 32'h10 + i);
      check("stream wrn", wrn, i + 1);
      check("stream walu", walu, 32'h10 + i);
      check("stream m_ready", m_ready, 1);
    end
    offer(0, 0, 0);
    check("bubble w_valid", w_valid, 0);
    check("bubble wwreg", wwreg, 0);
    check("bubble wrn", wrn, 4);
    w_ready = 0;
    offer(1, 7, 32'hA);
    offer(1, 8, 32'hB);
    check("bp m_ready", m_ready, 0);
    check("bp wrn A", wrn, 7);
    w_ready = 1;
    offer(0, 0, 0);
    check("bp wrn B", wrn, 8);
    check("bp m_ready after A", m_ready, 1);
    offer(0, 0, 0);
    check("bp drained", w_valid, 0);
    w_ready = 0;
    offer(1, 5, 32'h5);
    offer(1, 6, 32'h6);
    flush = 1;
    offer(1, 9, 32'h9);
    flush = 0;
    check("flush w_valid", w_valid, 0);
    check("flush m_ready", m_ready, 1);
    check("flush wrn kept", wrn, 5);
    w_ready = 1;
    repeat (3) begin
      offer(0, 0, 0);
      check("flush no 9", w_valid, 0);
    end
    w_ready = 0;
    offer(1, 10, 32'h10A);
    offer(1, 11, 32'h10B);
    m_valid = 0;
    @(posedge clock);
    #2 reset = 1;
    #1;
    check("areset wrn", wrn, 0);
    check("areset walu", walu, 0);
    check("areset w_valid", w_valid, 0);
    check("areset m_ready", m_ready, 1);
    @(negedge clock);
    reset = 0;
    w_ready = 1;
    offer(1, 12, 32'hC);
    check("post reset wrn", wrn, 12);
    check("post reset w_valid", w_valid, 1);
`ifdef PIPE_MW_STALL_CNT_EN
    offer(0, 0, 0);
    w_ready = 0;
    offer(1, 3, 32'h3);
    m_valid = 0;
    repeat (20) @(negedge clock);
    check("stall sat", stall_cnt, 15);
    flush = 1;
    @(negedge clock);
    flush = 0;
    @(negedge clock);
    check("stall after flush", stall_cnt, 15);
    reset = 1;
    @(negedge clock);
    check("stall reset", stall_cnt, 0);
    reset = 0;
`endif
    for (int i = 0; i < 3000; i++) begin
      m_valid = $urandom_range(0, 3) != 0;
      w_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      mwreg = $urandom_range(0, 1);
      mm2reg = $urandom_range(0, 1);
      mmo = $urandom;
      malu = $urandom;
      mrn = 5'($urandom_range(0, 31));
      @(negedge clock);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_mw_elastic.md
Name: pipe_mw_elastic

Overview:
- Parametrised, elastic MEM->WB pipeline stage register.
- Successor to the fixed-width MEM/WB flop stage: generalised widths, valid/ready handshake on both sides, 2-entry skid buffer, synchronous flush.
- Sits between the memory stage and the register-file write port.
- Lets WB back-pressure MEM without losing a result; guarantees bubbles never write the register file.

Parameters:
- DATA_W, 32, width of memory-read data and ALU result.
- RN_W, 5, width of destination register number.
- CNT_W, 16, width of stall counter (optional feature only).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; drops all held entries.
- m_valid  in  1  MEM side offers a payload.
- m_ready  out  1  stage can accept a payload.
- mwreg  in  1  register-write enable from MEM.
- mm2reg  in  1  select memory data for write-back.
- mmo  in  DATA_W  memory read data.
- malu  in  DATA_W  ALU result.
- mrn  in  RN_W  destination register number.
- w_valid  out  1  WB payload valid.
- w_ready  in  1  WB consumes payload this cycle.
- wwreg  out  1  register-write enable, gated by w_valid.
- wm2reg  out  1  memory-select, gated by w_valid.
- wmo  out  DATA_W  memory data.
- walu  out  DATA_W  ALU result.
- wrn  out  RN_W  destination register number.
- stall_cnt  out  CNT_W  present only with PIPE_MW_STALL_CNT_EN.

Behaviour:
- Handshake events:
  - in_fire = m_valid & m_ready.
  - out_fire = w_valid & w_ready.
- Storage:
  - main slot drives the W outputs.
  - skid slot holds one overflow payload.
- m_ready = ~skid_valid. It is a registered state bit, with no combinational path from w_ready.
- States and transitions:
  - EMPTY (main invalid)
    - in_fire: main<=in, go to ONE.
    - otherwise: stay.
  - ONE (main valid, skid empty)
    - in_fire & out_fire: main<=in, stay ONE.
    - in_fire & !out_fire: skid<=in, go to FULL.
    - !in_fire & out_fire: go to EMPTY.
    - neither: hold.
  - FULL (both valid, m_ready=0)
    - out_fire: main<=skid, go to ONE.
    - otherwise: hold.
- w_valid = 1 in ONE and FULL.
- Latency and ordering:
  - 1 cycle from in_fire to w_valid when the stage was EMPTY.
  - Strict FIFO order; no payload dropped or duplicated.
- Output gating:
  - wwreg = main.wreg & w_valid; wm2reg = main.m2reg & w_valid.
  - A bubble can never write the register file.
- Data outputs (wmo, walu, wrn) keep their last loaded value when invalid.
- Flush:
  - Highest priority; next state EMPTY regardless of in_fire/out_fire.
  - A payload offered in the same cycle is discarded.
  - Data slots are not cleared.
- Reset (asynchronous, any cycle, including mid-transfer):
  - state EMPTY; all slot contents 0.
  - w_valid=0, wwreg=0, wm2reg=0, wmo=0, walu=0, wrn=0.
  - m_ready=1 while in reset and after release.
- Steady streaming with w_ready=1: 1 payload per cycle, skid never used.
- Width rules: payload copied bit-exact; no arithmetic on data.

Optional Feature:
- Macro: PIPE_MW_STALL_CNT_EN.
- Defined:
  - Port stall_cnt exists.
  - Increments by 1 each cycle with w_valid & ~w_ready.
  - Saturates at 2^CNT_W-1.
  - Reset clears it to 0; flush does not clear it.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_mw_pkg holds:
  - Default width constants.
  - mw_payload_t struct {wreg, m2reg, mo, alu, rn}, parametrised through package constants.
  - State enum {EMPTY, ONE, FULL}.
- Sub-module pipe_mw_slot:
  - Load-enabled payload register with asynchronous reset.
  - Instantiated twice (main, skid).
- The top holds the FSM, muxing, output gating and the optional counter.

Test Plan:
- Reset then stream: w_ready=1; send 4 payloads mrn=1..4, malu=0x10..0x13 on consecutive cycles -> wrn=1..4 one cycle later each; m_ready stays 1.
- Back-pressure: send A (mrn=7), B (mrn=8) with w_ready=0 -> FULL, m_ready=0. Raise w_ready -> A then B on consecutive cycles; m_ready=1 after A leaves.
- Bubble gating: load payload with mwreg=1, consume it, hold m_valid=0 -> w_valid=0 and wwreg=0 while wrn keeps its last value.
- Flush in FULL with simultaneous m_valid=1 (mrn=9) -> next cycle w_valid=0, m_ready=1; mrn=9 never appears.
- Async reset mid-FULL, asserted between clock edges -> outputs 0 immediately, w_valid=0; after release a new payload passes with 1-cycle latency.
- With PIPE_MW_STALL_CNT_EN, CNT_W=4: hold w_valid=1, w_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush leaves it at 15; reset clears it to 0.
